// File: rtl/intermediate_pipe_stage_if.sv
// rtl/intermediate_pipe_stage_if.sv - valid/ready beat channel into and out of the inter-stage register pipe
interface intermediate_pipe_stage_if #(
   parameter int NUM_LANES  = 8,
   parameter int DATA_WIDTH = 32
);
   logic                            in_valid;
   logic                            in_ready;
   logic [NUM_LANES*DATA_WIDTH-1:0] in_data;
   logic                            in_reorder;
   logic                            out_valid;
   logic                            out_ready;
   logic [NUM_LANES*DATA_WIDTH-1:0] out_data;

   // pipe side: consumes the upstream beat, produces the downstream beat
   modport slave (
      input  in_valid, in_data, in_reorder, out_ready,
      output in_ready, out_valid, out_data
   );

   // environment side: drives beats in, accepts beats out
   modport master (
      output in_valid, in_data, in_reorder, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/intermediate_pipe_stage.sv
// rtl/intermediate_pipe_stage.sv - elastic multi-lane register pipe with optional bit-reversed lane capture
module intermediate_pipe_stage #(
   parameter int NUM_LANES  = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1,
   parameter int REORDER_EN = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   intermediate_pipe_stage_if.slave bus,
   output logic [2:0]              occupancy,
   output logic [15:0]             beat_count
);
   localparam int LW         = NUM_LANES * DATA_WIDTH;
   localparam int LOG2_LANES = $clog2(NUM_LANES);

   logic [LW-1:0]    stage_data [DEPTH];
   logic [DEPTH-1:0] stage_valid;
   logic [DEPTH-1:0] adv;
   logic             chain_room;
   logic [LW-1:0]    cap_data;
   logic             deliver;

   // mirror the low LOG2_LANES bits of a lane index
   function automatic int bitrev(input int lane);
      int r;
      r = 0;
      for (int b = 0; b < LOG2_LANES; b++) begin
         if (((lane >> b) & 1) != 0) begin
            r = r | (1 << (LOG2_LANES - 1 - b));
         end
      end
      return r;
   endfunction

   // a stage may load when it or any stage after it is empty, or when the output is draining
   always_comb begin
      chain_room = bus.out_ready;
      adv        = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
         chain_room = chain_room | ~stage_valid[s];
         adv[s]     = chain_room;
      end
   end

   assign bus.in_ready  = adv[0] & rst;
   assign bus.out_valid = stage_valid[DEPTH-1];
   assign bus.out_data  = stage_data[DEPTH-1];
   assign deliver       = stage_valid[DEPTH-1] & bus.out_ready;

   // lane permutation applied as the beat enters stage 0
   always_comb begin
      cap_data = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if ((REORDER_EN != 0) && bus.in_reorder) begin
            cap_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data[bitrev(k)*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            cap_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // stage 0 captures the upstream beat (or a bubble) whenever it can advance
   always_ff @(posedge clk) begin
      if (!rst) begin
         stage_valid[0] <= 1'b0;
         stage_data[0]  <= '0;
      end else if (adv[0]) begin
         stage_valid[0] <= bus.in_valid;
         stage_data[0]  <= cap_data;
      end
   end

   // later stages shift forward from their predecessor, holding while blocked
   always_ff @(posedge clk) begin
      for (int s = 1; s < DEPTH; s++) begin
         if (!rst) begin
            stage_valid[s] <= 1'b0;
            stage_data[s]  <= '0;
         end else if (adv[s]) begin
            stage_valid[s] <= stage_valid[s-1];
            stage_data[s]  <= stage_data[s-1];
         end
      end
   end

   // number of stages currently holding a real beat
   always_comb begin
      occupancy = '0;
      for (int s = 0; s < DEPTH; s++) begin
         occupancy = occupancy + 3'(stage_valid[s]);
      end
   end

   // free-running count of delivered beats, wrapping at 16 bits
   always_ff @(posedge clk) begin
      if (!rst) begin
         beat_count <= '0;
      end else if (deliver) begin
         beat_count <= beat_count + 16'd1;
      end
   end
endmodule
